// File: rtl/spi_regfile_slave_if.sv
// SPI pin bundle between the MCU master and the register-file slave.
interface spi_regfile_slave_if;
    logic sclk;
    logic mosi;
    logic cs;
    logic miso;

    modport master (output sclk, output mosi, output cs, input miso);
    modport slave  (input sclk, input mosi, input cs, output miso);
endinterface

// File: rtl/spi_regfile_slave.sv
// Oversampled SPI slave (mode 0, MSB first) writing/reading a bank of N_REG registers.
// Define SPI_AUTOINC_EN to keep streaming words with an auto-incrementing address.
//
// state | meaning
// IDLE  | waiting for cs to fall
// CMD   | shifting in the 8-bit command (bit7 write, bits 6:0 address)
// DATA  | shifting data in on sclk rise, read data out on sclk fall
// DONE  | frame complete; ignore sclk until cs rises
module spi_regfile_slave #(
    parameter int              Nbit     = 8,
    parameter int              N_REG    = 4,
    parameter int              BASE_ADR = 1,
    parameter logic [Nbit-1:0] RST_VAL  = '1
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_regfile_slave_if.slave    spi,
    output logic [N_REG*Nbit-1:0] out,
    output logic [N_REG-1:0]      wr_stb
);

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    state_t                       state_q, state_d;
    logic [2:0]                   sclk_sync_q, sclk_sync_d;
    logic [2:0]                   cs_sync_q, cs_sync_d;
    logic [1:0]                   mosi_sync_q, mosi_sync_d;
    logic [4:0]                   bit_cnt_q, bit_cnt_d;
    logic [6:0]                   cmd_sr_q, cmd_sr_d;
    logic                         wr_q, wr_d;
    logic [6:0]                   adr_q, adr_d;
    logic [Nbit-1:0]              rx_sr_q, rx_sr_d;
    logic [Nbit-1:0]              tx_sr_q, tx_sr_d;
    logic [N_REG-1:0][Nbit-1:0]   reg_q, reg_d;
    logic [N_REG-1:0]             wr_stb_q, wr_stb_d;
    logic                         miso_q, miso_d;

    logic                         sclk_rise, sclk_fall, cs_hi, cs_fall, mosi_s;
    logic [7:0]                   cmd_next;
    logic [Nbit-1:0]              rx_next;

    function automatic logic adr_hit(input logic [6:0] a);
        return (int'(a) >= BASE_ADR) && (int'(a) < BASE_ADR + N_REG);
    endfunction

    function automatic logic [Nbit-1:0] reg_rd(input logic [6:0] a,
                                               input logic [N_REG-1:0][Nbit-1:0] r);
        logic [Nbit-1:0] v;
        v = '0;
        for (int i = 0; i < N_REG; i++)
            if (int'(a) == BASE_ADR + i) v = r[i];
        return v;
    endfunction

    // Edge events come from stages 2/3 so mosi (stage 2) lines up with the sclk rise.
    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign cs_hi     = cs_sync_q[1];
    assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
    assign mosi_s    = mosi_sync_q[1];

    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], spi.sclk};
        cs_sync_d   = {cs_sync_q[1:0], spi.cs};
        mosi_sync_d = {mosi_sync_q[0], spi.mosi};
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        cmd_sr_d    = cmd_sr_q;
        wr_d        = wr_q;
        adr_d       = adr_q;
        rx_sr_d     = rx_sr_q;
        tx_sr_d     = tx_sr_q;
        reg_d       = reg_q;
        wr_stb_d    = '0;
        miso_d      = miso_q;
        cmd_next    = {cmd_sr_q, mosi_s};
        rx_next     = rx_sr_q << 1;
        rx_next[0]  = mosi_s;

        if (cs_hi) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            miso_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    miso_d = 1'b0;
                    if (cs_fall) begin
                        state_d   = CMD;
                        bit_cnt_d = '0;
                    end
                end
                CMD: begin
                    miso_d = 1'b0;
                    if (sclk_rise) begin
                        cmd_sr_d = cmd_next[6:0];
                        if (bit_cnt_q == 5'd7) begin
                            wr_d      = cmd_next[7];
                            adr_d     = cmd_next[6:0];
                            bit_cnt_d = '0;
                            state_d   = DATA;
                            tx_sr_d   = (!cmd_next[7] && adr_hit(cmd_next[6:0]))
                                        ? reg_rd(cmd_next[6:0], reg_q) : '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end
                DATA: begin
                    if (sclk_fall) begin
                        miso_d  = tx_sr_q[Nbit-1];
                        tx_sr_d = tx_sr_q << 1;
                    end
                    if (sclk_rise) begin
                        rx_sr_d = rx_next;
                        if (bit_cnt_q == 5'(Nbit-1)) begin
                            bit_cnt_d = '0;
                            if (wr_q && adr_hit(adr_q)) begin
                                for (int i = 0; i < N_REG; i++) begin
                                    if (int'(adr_q) == BASE_ADR + i) begin
                                        reg_d[i]    = rx_next;
                                        wr_stb_d[i] = 1'b1;
                                    end
                                end
                            end
`ifdef SPI_AUTOINC_EN
                            adr_d = adr_q + 7'd1;
                            if (!wr_q)
                                tx_sr_d = adr_hit(adr_q + 7'd1)
                                          ? reg_rd(adr_q + 7'd1, reg_q) : '0;
`else
                            state_d = DONE;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end
                DONE:    miso_d  = 1'b0;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            bit_cnt_q   <= '0;
            cmd_sr_q    <= '0;
            wr_q        <= 1'b0;
            adr_q       <= '0;
            rx_sr_q     <= '0;
            tx_sr_q     <= '0;
            reg_q       <= {N_REG{RST_VAL}};
            wr_stb_q    <= '0;
            miso_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            bit_cnt_q   <= bit_cnt_d;
            cmd_sr_q    <= cmd_sr_d;
            wr_q        <= wr_d;
            adr_q       <= adr_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            reg_q       <= reg_d;
            wr_stb_q    <= wr_stb_d;
            miso_q      <= miso_d;
        end
    end

    assign out      = reg_q;
    assign wr_stb   = wr_stb_q;
    assign spi.miso = miso_q;

endmodule

// File: tb/tb_spi_regfile_slave.sv
// Directed scoreboard bench for spi_regfile_slave (Nbit=8, N_REG=4, BASE_ADR=1, clk = 8x sclk).
module tb_spi_regfile_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] out;
    logic [3:0]  wr_stb;

    spi_regfile_slave_if spi ();

    spi_regfile_slave #(.Nbit(8), .N_REG(4), .BASE_ADR(1)) dut (
        .clk    (clk),
        .rst    (rst),
        .spi    (spi),
        .out    (out),
        .wr_stb (wr_stb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] stb;
        logic [7:0] val;
    } stb_t;

    stb_t        stb_q[$];
    stb_t        stb_e;
    logic [7:0]  rd_q[$];
    logic [7:0]  mdl[4];
    logic [47:0] rx_bits;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe monitor: every nonzero strobe cycle must match the next expected write.
    always @(negedge clk) begin
        if (!rst && wr_stb !== 4'b0000) begin
            if (stb_q.size() == 0) begin
                check("stb_unexpected", 64'(wr_stb), 64'd0);
            end else begin
                stb_e = stb_q.pop_front();
                check("stb", 64'(wr_stb), 64'(stb_e.stb));
                for (int i = 0; i < 4; i++)
                    if (stb_e.stb[i]) check("stb_val", 64'(out[i*8 +: 8]), 64'(stb_e.val));
            end
        end
    end

    // Mode-0 master: mosi changes while sclk low, miso sampled at each sclk rise.
    task automatic xfer(input int nbits, input logic [47:0] tx);
        rx_bits = '0;
        @(negedge clk);
        spi.cs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            spi.mosi = tx[i];
            repeat (4) @(negedge clk);
            spi.sclk   = 1'b1;
            rx_bits[i] = spi.miso;
            repeat (4) @(negedge clk);
            spi.sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
        spi.mosi = 1'b0;
        spi.cs   = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic expect_write(input logic [6:0] a, input logic [7:0] d);
        int idx;
        idx = int'(a) - 1;
        if (idx >= 0 && idx < 4) begin
            mdl[idx] = d;
            stb_q.push_back('{stb: 4'(1 << idx), val: d});
        end
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] d);
        expect_write(a, d);
        xfer(16, {32'h0, 1'b1, a, d});
    endtask

    task automatic do_read(input logic [6:0] a, input string tag);
        int idx;
        idx = int'(a) - 1;
        rd_q.push_back((idx >= 0 && idx < 4) ? mdl[idx] : 8'h00);
        xfer(16, {32'h0, 1'b0, a, 8'h00});
        check(tag, 64'(rx_bits[7:0]), 64'(rd_q.pop_front()));
    endtask

    task automatic check_bank(input string tag);
        check(tag, 64'(out), 64'({mdl[3], mdl[2], mdl[1], mdl[0]}));
    endtask

    initial begin
        spi.sclk = 1'b0;
        spi.mosi = 1'b0;
        spi.cs   = 1'b1;
        for (int i = 0; i < 4; i++) mdl[i] = 8'hFF;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_out", 64'(out), 64'hFFFF_FFFF);
        check("rst_stb", 64'(wr_stb), 64'd0);
        check("rst_miso", 64'(spi.miso), 64'd0);

        do_write(7'h02, 8'h5A);
        check_bank("bank_after_w2");

        do_write(7'h01, 8'h3C);
        do_read(7'h01, "rd_reg0");
        check_bank("bank_after_rd0");

        do_write(7'h05, 8'h11);
        do_write(7'h00, 8'h77);
        do_read(7'h7F, "rd_oor_7f");
        do_read(7'h00, "rd_oor_00");
        check_bank("bank_after_oor");

        xfer(12, {36'h0, 8'h83, 4'hA});
        check_bank("bank_after_abort");
        check("miso_cs_high", 64'(spi.miso), 64'd0);
        do_write(7'h03, 8'hA5);
        do_write(7'h04, 8'hC3);
        check_bank("bank_after_w3_w4");
        do_read(7'h04, "rd_reg3");
        do_read(7'h02, "rd_reg1");

`ifdef SPI_AUTOINC_EN
        for (int k = 0; k < 4; k++) expect_write(7'(k + 1), 8'(k + 1));
`else
        expect_write(7'h01, 8'h01);
`endif
        xfer(40, {8'h00, 8'h81, 8'h01, 8'h02, 8'h03, 8'h04});
        check_bank("bank_after_burst");
        do_read(7'h01, "rd_burst_r0");
        do_read(7'h03, "rd_burst_r2");

        repeat (4) @(negedge clk);
        check("stb_pending", 64'(stb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_regfile_slave.md
Name: spi_regfile_slave

Overview:
- Parametrised successor to the single-register SPI write receiver.
- Accepts 8-bit command + Nbit data frames from the MCU SPI master (mode 0, MSB first) and writes into a bank of N_REG registers.
- Supports register read-back on miso and emits a per-register write strobe.
- Fully synchronous to the FPGA clock `clk`: sclk, cs and mosi are oversampled, so there is no sclk clock domain inside the block.

Parameters:
- Nbit, 8: data word width, 1..32.
- N_REG, 4: number of registers, 1..16.
- BASE_ADR, 1: 7-bit SPI address of register 0. Register i answers at BASE_ADR+i.
- RST_VAL, all ones: reset value of every register.

Ports:
- clk  in  1  system clock; must run at ≥ 8× sclk.
- rst  in  1  synchronous, active-high reset.
- sclk  in  1  SPI clock, asynchronous to clk.
- mosi  in  1  SPI data from master.
- cs  in  1  SPI chip select, active low.
- miso  out  1  SPI data to master. 0 while cs is high.
- out  out  N_REG*Nbit  register bank; register i is out[i*Nbit +: Nbit].
- wr_stb  out  N_REG  one-clk pulse on bit i when register i is written.

Behaviour:
- Reset: rst is sampled on the rising edge of clk.
  - All registers ← RST_VAL; wr_stb=0; miso=0.
  - State=IDLE; bit counter=0; synchronisers cleared (cs sync stage cleared to 1).
  - rst coincident with a commit: rst wins.
- Input sync:
  - sclk, cs and mosi each pass through a 2-FF synchroniser plus a third stage for edge detect.
  - A rising or falling sclk event is seen 3 clk after the pin edge.
  - mosi is sampled together with the sclk rising event, from the same synchroniser depth.
- Frame: cs low, then 8 command bits, then Nbit data bits.
  - Command bit7: 1=write, 0=read. Bits 6:0 = address.
  - Address is in range iff BASE_ADR ≤ adr < BASE_ADR+N_REG.
- FSM:
  - IDLE → CMD on synchronised cs falling.
  - CMD: shift mosi on each sclk rise. On the 8th bit: latch cmd/adr, then → DATA.
  - DATA:
    - On each sclk rise, shift mosi into rx_sr.
    - On the Nbit-th bit: if write and address in range, register[adr-BASE_ADR] ← rx_sr on the next clk and wr_stb bit pulses high for exactly 1 clk in that same cycle. Then → DONE.
  - DONE: ignore sclk and hold miso at 0 until cs goes high.
  - From any state, synchronised cs high → IDLE. The partial frame is discarded with no register change and no strobe.
- Read path:
  - When the command is latched as read, tx_sr loads register[adr-BASE_ADR], or 0 if the address is out of range.
  - On each sclk fall event while in DATA, miso ← tx_sr MSB and tx_sr shifts left.
  - The first data bit appears after the sclk fall that follows the 8th command rise, so the master samples it on rise 9.
  - miso is a registered output.
- Out-of-range write: the frame is consumed, but no register changes and no strobe fires.
- Counters:
  - The bit counter counts 0..7 in CMD and 0..Nbit-1 in DATA.
  - No wrap beyond that without the optional feature.
- Register contents change only on a committed write; reads do not modify them.

Optional Feature:
- Macro: SPI_AUTOINC_EN.
- Defined:
  - After each completed data word, adr ← adr+1 and the FSM stays in DATA for another word, indefinitely, until cs goes high.
  - Writes commit per word using the in-range test on the current adr. Reads reload tx_sr from the new adr, or 0 if out of range.
  - adr is 7 bits and wraps 127→0.
- Not defined:
  - One word per frame. Extra clocks are ignored in DONE.

Test Plan (Nbit=8, N_REG=4, BASE_ADR=1, clk=8×sclk):
- Reset → out = 0xFFFFFFFF, wr_stb=0, miso=0.
- Write 0x82,0x5A → register1 = 0x5A. wr_stb=0b0010 for exactly 1 clk. All other registers unchanged.
- Write 0x81,0x3C, then read 0x01 → miso shifts out 0x3C MSB first, sampled on sclk rises 9..16.
- Write 0x85,0x11 (out of range), then read 0x7F → no register change, no strobe; read returns 0x00.
- Write 0x83, then 4 data bits, then cs high → register2 keeps 0xFF and no strobe fires. The next full frame 0x83,0xA5 writes 0xA5.
- SPI_AUTOINC_EN: write 0x81,0x01,0x02,0x03,0x04 in one cs-low frame → registers 0..3 = 01,02,03,04 and four single strobes in order. Without the macro, only register0 = 0x01.
